// File: rtl/noc_pkt_store_fwd.sv
// -----------------------------------------------------------------------------
// noc_pkt_store_fwd
//
// Store-and-forward flit buffer between the per-node 2:1 arbiter and the
// fabric interface. A packet becomes visible on the output only after its tail
// flit is stored, so the fabric never holds a stalled partial packet.
// SOP/EOP framing is enforced: stray body/tail flits are dropped, a packet cut
// short by a new head is rewound out of the buffer, and a packet longer than
// MAX_PKT_FLITS is rewound and the rest of it discarded up to its tail.
//
// Flit layout: [W-1] valid flag, [W-2] head, tail = any of
// [W-3], [W-153], [W-303], [W-453].
//
// Ports
//   clk              in   clock
//   reset_n          in   asynchronous active-low reset
//   i_data_in        in   flit from arbiter
//   i_valid_in       in   flit valid
//   i_ready_out      out  block accepts a flit this cycle
//   o_data_out       out  flit to fabric interface (show-ahead)
//   o_valid_out      out  a complete packet is available
//   o_ready_in       in   fabric interface ready
//   o_pkt_fwd_count  out  (NOC_SAF_STATS_EN only) tails read out, wrapping
//   o_err_count      out  (NOC_SAF_STATS_EN only) framing errors, saturating
//
// Build option: define NOC_SAF_STATS_EN to add the two statistics counters.
// -----------------------------------------------------------------------------
module noc_pkt_store_fwd #(
    parameter int NOC_WIDTH     = 600,
    parameter int DEPTH         = 32,
    parameter int MAX_PKT_FLITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NOC_WIDTH-1:0] i_data_in,
    input  logic                 i_valid_in,
    output logic                 i_ready_out,
    output logic [NOC_WIDTH-1:0] o_data_out,
    output logic                 o_valid_out,
    input  logic                 o_ready_in
`ifdef NOC_SAF_STATS_EN
    ,
    output logic [31:0]          o_pkt_fwd_count,
    output logic [15:0]          o_err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;                        // extra bit separates full from empty
    localparam int LW = $clog2(MAX_PKT_FLITS) + 1;
    localparam int CW = AW + 1;                        // up to DEPTH one-flit packets

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_PKT_FLITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DROP
    } state_t;

    function automatic logic is_tail(input logic [NOC_WIDTH-1:0] f);
        return f[NOC_WIDTH-3] | f[NOC_WIDTH-153] | f[NOC_WIDTH-303] | f[NOC_WIDTH-453];
    endfunction

    state_t         state_q, state_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  pkt_start_q, pkt_start_d;
    logic [LW-1:0]  len_q, len_d;
    logic [CW-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [NOC_WIDTH-1:0] mem [DEPTH];
    logic [NOC_WIDTH-1:0] rd_data;

    logic           full;
    logic           flit_acc;
    logic           in_head;
    logic           in_tail;
    logic           rewind;
    logic           new_head;
    logic           append;
    logic           err_inc;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [PW-1:0]  base;
    logic           rd_xfer;
    logic           tail_wr;
    logic           tail_rd;

    assign full        = (wptr_q - rptr_q) == PTR_DEPTH;
    // Ready is gated by reset_n so it falls immediately when reset asserts.
    assign i_ready_out = reset_n & ((state_q == ST_DROP) | ~full);
    assign flit_acc    = i_valid_in & i_ready_out & i_data_in[NOC_WIDTH-1];
    assign in_head     = i_data_in[NOC_WIDTH-2];
    assign in_tail     = is_tail(i_data_in);

    assign rd_data     = mem[rptr_q[AW-1:0]];
    assign o_valid_out = (pkt_cnt_q != '0);
    assign o_data_out  = o_valid_out ? rd_data : '0;
    assign rd_xfer     = o_valid_out & o_ready_in;
    assign tail_rd     = rd_xfer & is_tail(rd_data);

    // Framing decisions for the flit accepted this cycle.
    always_comb begin
        rewind   = 1'b0;
        new_head = 1'b0;
        append   = 1'b0;
        err_inc  = 1'b0;
        state_d  = state_q;
        if (flit_acc) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_head) new_head = 1'b1;
                    else         err_inc  = 1'b1;   // stray body or tail
                end
                ST_PKT: begin
                    if (in_head) begin
                        // Truncated packet: drop the partial, restart on this head.
                        rewind   = 1'b1;
                        err_inc  = 1'b1;
                        new_head = 1'b1;
                    end else if (in_tail) begin
                        append   = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (len_q == LEN_LAST) begin
                        // A further body flit could not be closed within the limit.
                        rewind   = 1'b1;
                        err_inc  = 1'b1;
                        state_d  = ST_DROP;
                    end else begin
                        append   = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (in_head) begin
                        new_head = 1'b1;
                        err_inc  = ~in_tail;
                    end else if (in_tail) begin
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (new_head) state_d = in_tail ? ST_IDLE : ST_PKT;
        end
    end

    // Write side: a rewind and the write of a new head share one base pointer.
    always_comb begin
        base        = rewind ? pkt_start_q : wptr_q;
        wr_en       = new_head | append;
        wr_addr     = base[AW-1:0];
        wptr_d      = wr_en ? (base + PTR_ONE) : base;
        pkt_start_d = new_head ? base : pkt_start_q;
        len_d       = new_head ? LEN_ONE : (append ? (len_q + LEN_ONE) : len_q);
        tail_wr     = wr_en & in_tail;
        rptr_d      = rd_xfer ? (rptr_q + PTR_ONE) : rptr_q;
        unique case ({tail_wr, tail_rd})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pkt_start_q <= '0;
            len_q       <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pkt_start_q <= pkt_start_d;
            len_q       <= len_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Flit storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= i_data_in;
    end

`ifdef NOC_SAF_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        fwd_cnt_d = fwd_cnt_q + {31'd0, tail_rd};
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_pkt_fwd_count = fwd_cnt_q;
    assign o_err_count     = err_cnt_q;
`else
    logic stats_unused;
    assign stats_unused = err_inc;
`endif

endmodule
